fifo_wr_ctrl: RTL and testbench

Write-side controller for the dual-clock FIFO. It lives in the write clock domain and owns the binary and Gray write pointers. It issues the memory write enable and address, and derives `full`, occupancy level, overflow and optional almost-full flags. It compares its own pointer against the read-side Gray pointer, which arrives through the 2-stage pointer synchronizer. Its `wr_gray` output is the value the read domain synchronizes.

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/fifo_gray_ptr.sv | 44 ++++
 rtl/fifo_wr_ctrl.sv | 106 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers.
// Gray conversion, depth derivation and the pointer-full compare.
package fifo_pkg;

    localparam int PTR_MAX = 32;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(
        input logic [PTR_MAX-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(
        input logic [PTR_MAX-1:0] g
    );
        logic [PTR_MAX-1:0] b;
        b = g;
        for (int i = 1; i < PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Own Gray pointer equals the other side's with its top two bits inverted.
    function automatic logic ptr_full(
        input logic [PTR_MAX-1:0] own_g,
        input logic [PTR_MAX-1:0] oth_g,
        input int                 aw
    );
        logic [PTR_MAX-1:0] m;
        m = 32'd3 << (aw - 1);
        return own_g == (oth_g ^ m);
    endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary + Gray pointer register with increment enable.
// Exposes both current and next values for flag computation.
module fifo_gray_ptr
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] bin_n,
    output logic [W-1:0] gray,
    output logic [W-1:0] gray_n
);

    logic [W-1:0] bin_q;
    logic [W-1:0] bin_d;
    logic [W-1:0] gray_q;
    logic [W-1:0] gray_d;

    // Next pointer values; wrap is natural modulo 2^W.
    always_comb begin
        bin_d  = bin_q + W'(inc);
        gray_d = W'(bin2gray(PTR_MAX'(bin_d)));
    end

    // Pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin    = bin_q;
    assign bin_n  = bin_d;
    assign gray   = gray_q;
    assign gray_n = gray_d;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO.
// Optional almost-full flag: define FIFO_WR_CTRL_AFULL_EN.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   rd_gray_sync,
    input  logic                  ovf_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  afull,
    output logic                  ovf
);

    localparam int PW = ADDR_WIDTH + 1;

    logic          acc;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_bin_n;
    logic [PW-1:0] wr_gray_n;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] level_n;
    logic          full_q;
    logic          full_d;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_d;
    logic          ovf_q;
    logic          ovf_d;

    assign acc   = wr_req & ~full_q;
    assign wr_en = acc & ~rst;

    fifo_gray_ptr #(
        .W (PW)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc    (acc),
        .bin    (wr_bin),
        .bin_n  (wr_bin_n),
        .gray   (wr_gray),
        .gray_n (wr_gray_n)
    );

    assign wr_addr = wr_bin[ADDR_WIDTH-1:0];

    // Flags computed from the post-write pointer so no extra accept slips in.
    always_comb begin
        rd_bin  = PW'(gray2bin(PTR_MAX'(rd_gray_sync)));
        level_n = wr_bin_n - rd_bin;
        level_d = level_n;
        full_d  = ptr_full(PTR_MAX'(wr_gray_n),
                           PTR_MAX'(rd_gray_sync), ADDR_WIDTH);
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (wr_req && full_q) ovf_d = 1'b1;
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full  = full_q;
    assign level = level_q;
    assign ovf   = ovf_q;

`ifdef FIFO_WR_CTRL_AFULL_EN
    localparam logic [PW-1:0] TH = PW'(AFULL_TH);

    logic afull_q;
    logic afull_d;

    // Almost-full threshold on the next occupancy.
    always_comb begin
        afull_d = (level_n >= TH);
    end

    // Almost-full register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) afull_q <= 1'b0;
        else     afull_q <= afull_d;
    end

    assign afull = afull_q;
`else
    assign afull = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=3).
// Expectations for afull follow FIFO_WR_CTRL_AFULL_EN.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_CTRL_AFULL_EN
    localparam bit AFE = 1'b1;
`else
    localparam bit AFE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req;
    logic [3:0] rd_gray_sync;
    logic       ovf_clr;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_gray;
    logic       full;
    logic [3:0] level;
    logic       afull;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH (3),
        .AFULL_TH   (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_gray_sync (rd_gray_sync),
        .ovf_clr      (ovf_clr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_gray      (wr_gray),
        .full         (full),
        .level        (level),
        .afull        (afull),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev;
    int         b;
    bit         seen_wrap;

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_gray_sync = 4'b0; ovf_clr = 1'b0;
        // reset with clock running, even with a request
        tick(); tick();
        wr_req = 1'b1; #1;
        chk("rst_wr_en", wr_en, 0);
        tick();
        chk("rst_gray", wr_gray, 4'b0000);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_afull", afull, 0);
        wr_req = 1'b0;
        rst = 1'b0;
        tick(); tick();
        chk("idle_gray", wr_gray, 0);
        chk("idle_level", level, 0);

        // fill eight entries
        for (int i = 0; i < 8; i++) begin
            wr_req = 1'b1; #1;
            chk("fill_full_pre", full, 0);
            chk("fill_wr_en", wr_en, 1);
            chk("fill_addr", wr_addr, i);
            tick();
        end
        wr_req = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_level", level, 8);
        chk("fill_gray", wr_gray, 4'b1100);
        chk("fill_afull", afull, AFE);

        // overflow
        wr_req = 1'b1; #1;
        chk("ovf_wr_en", wr_en, 0);
        chk("ovf_addr", wr_addr, 0);
        tick();
        chk("ovf_set", ovf, 1);
        chk("ovf_gray", wr_gray, 4'b1100);
        chk("ovf_level", level, 8);
        ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", ovf, 1);
        wr_req = 1'b0;
        tick();
        chk("ovf_clr", ovf, 0);
        ovf_clr = 1'b0;

        // drain one entry
        rd_gray_sync = 4'b0001;
        tick();
        chk("drain_full", full, 0);
        chk("drain_level", level, 7);
        chk("drain_afull", afull, AFE);
        wr_req = 1'b1; #1;
        chk("drain_wr_en", wr_en, 1);
        chk("drain_addr", wr_addr, 0);
        tick();
        wr_req = 1'b0;
        chk("refill_full", full, 1);
        chk("refill_level", level, 8);

        // wrap with reader two entries behind
        b = 9;
        rd_gray_sync = g(b - 2);
        tick();
        chk("wrap_lvl0", level, 2);
        chk("wrap_full0", full, 0);
        seen_wrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev = wr_gray;
            wr_req = 1'b1;
            rd_gray_sync = g(b - 1);
            tick();
            b++;
            chk("wrap_gray", wr_gray, g(b));
            chk("wrap_1bit", $countones(prev ^ wr_gray), 1);
            chk("wrap_level", level, 2);
            chk("wrap_full", full, 0);
            chk("wrap_afull", afull, 0);
            if (prev == 4'b1000 && wr_gray == 4'b0000) seen_wrap = 1'b1;
        end
        wr_req = 1'b0;
        chk("wrap_seen", seen_wrap, 1);

        // asynchronous reset mid-cycle
        @(negedge clk);
        wr_req = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_gray", wr_gray, 0);
        chk("arst_level", level, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_addr", wr_addr, 0);
        wr_req = 1'b0;
        rd_gray_sync = 4'b0;
        tick();
        rst = 1'b0;
        tick();

        // almost full
        for (int i = 0; i < 6; i++) begin
            chk("af_pre", afull, 0);
            wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
        chk("af_level6", level, 6);
        chk("af_set", afull, AFE);
        rd_gray_sync = g(1);
        tick();
        chk("af_level5", level, 5);
        chk("af_clr", afull, 0);
        chk("af_ovf", ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
